fetch_unit: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register. It consumes the current PC value, issues in-order requests to instruction memory and pairs each returned word with its PC.
- Buffers results in a small ring and presents them to decode with a valid/ready handshake.
- Drives the PC-advance enable and supports branch redirect by flushing in-flight and buffered fetches.

---
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, ring buffer of {pc, data}, flush by drop count.
// Optional misaligned-PC trap enabled by defining MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned DEPTH       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    output logic                   pc_advance,
    input  logic                   flush,
    output logic                   imem_req_valid,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    input  logic                   instr_ready,
    output logic                   fetch_fault
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW:0] DepthW = DEPTH[CntW:0];

    logic [ADDR_WIDTH-1:0]  pc_q   [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_d   [DEPTH];
    logic [INSTR_WIDTH-1:0] data_q [DEPTH];
    logic [INSTR_WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]       filled_q, filled_d;
    logic [PtrW-1:0]        alloc_ptr_q, alloc_ptr_d;
    logic [PtrW-1:0]        fill_ptr_q, fill_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        occ_q, occ_d;
    logic [CntW-1:0]        pend_q, pend_d;      // allocated but not yet filled
    logic [CntW-1:0]        drop_cnt_q, drop_cnt_d;
    logic [CntW:0]          outstanding;
    logic                   base_ok, issue_ok, trap, rsp_live, pop;

    assign outstanding = {1'b0, pend_q} + {1'b0, drop_cnt_q};
    assign base_ok     = rst_n && !flush && ({1'b0, occ_q} < DepthW) && (outstanding < DepthW);
    // A response with nothing outstanding is a system error and is ignored.
    assign rsp_live    = imem_rsp_valid && (outstanding != '0);

`ifdef MISALIGN_TRAP_EN
    logic fault_q, fault_d;

    assign issue_ok    = base_ok && !fault_q;
    assign trap        = issue_ok && (pc_addr[1:0] != 2'b00);
    assign fetch_fault = fault_q;

    always_comb begin
        fault_d = fault_q;
        if (flush) begin
            fault_d = 1'b0;
        end else if (trap) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    assign issue_ok    = base_ok;
    assign trap        = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign imem_req_valid = issue_ok && !trap;
    assign imem_req_addr  = pc_addr;
    assign pc_advance     = imem_req_valid && imem_req_ready;

    assign instr_valid = (occ_q != '0) && filled_q[rd_ptr_q];
    assign instr_data  = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];
    assign pop         = instr_valid && instr_ready;

    always_comb begin
        pc_d        = pc_q;
        data_d      = data_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        pend_d      = pend_q;
        drop_cnt_d  = drop_cnt_q;

        if (flush) begin
            // Everything still owed by memory must be discarded when it returns.
            drop_cnt_d  = drop_cnt_q + pend_q - CntW'(rsp_live);
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            pend_d      = '0;
        end else begin
            if (rsp_live) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CntW'(1);
                end else begin
                    data_d[fill_ptr_q]   = imem_rsp_data;
                    filled_d[fill_ptr_q] = 1'b1;
                    fill_ptr_d           = fill_ptr_q + PtrW'(1);
                    pend_d               = pend_d - CntW'(1);
                end
            end
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + PtrW'(1);
                occ_d              = occ_d - CntW'(1);
            end
            if (pc_advance) begin
                pc_d[alloc_ptr_q]     = pc_addr;
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + PtrW'(1);
                occ_d                 = occ_d + CntW'(1);
                pend_d                = pend_d + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            pend_q      <= '0;
            drop_cnt_q  <= '0;
        end else begin
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            pend_q      <= pend_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Payload is only meaningful where filled is set, so it needs no reset.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: in-order 1-cycle memory model, directed scenarios, FIFO monitor.
module tb_fetch_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned D  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] pc_addr;
    logic          pc_advance;
    logic          flush;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_rsp_valid = 1'b0;
    logic [IW-1:0] imem_rsp_data = '0;
    logic          instr_valid;
    logic [IW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          fetch_fault;

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_addr       (pc_addr),
        .pc_advance    (pc_advance),
        .flush         (flush),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          errors = 0;
    int          checks = 0;
    logic        mem_en = 1'b0;
    logic        pc_inc = 1'b0;

    // Memory: accept seen before edge N is answered during cycle N..N+1.
    initial begin
        logic        acc;
        logic [31:0] acc_addr;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            acc      = rst_n && imem_req_valid && imem_req_ready;
            acc_addr = imem_req_addr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_q.delete();
                pc_inc         = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                pc_inc = acc;
                if (acc) mem_q.push_back(acc_addr);
                if (mem_en && mem_q.size() > 0) begin
                    a              = mem_q.pop_front();
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = {16'hC0DE, a[15:0]};
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: every decode handshake must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready && !flush) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_instr: got pc=0x%0h data=0x%0h, none expected",
                             instr_pc, instr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (instr_pc !== e.pc || instr_data !== e.data) begin
                        errors++;
                        $display("FAIL instr_order: got pc=0x%0h data=0x%0h expected pc=0x%0h data=0x%0h",
                                 instr_pc, instr_data, e.pc, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one cycle; the bench plays the PC register.
    task automatic step();
        @(posedge clk);
        #2;
        if (pc_inc) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] data);
        exp_q.push_back('{pc: pc, data: data});
    endtask

    task automatic do_reset(input logic [31:0] pc0, input logic rq_rdy, input logic i_rdy,
                            input logic men);
        rst_n = 1'b0;
        flush = 1'b0;
        exp_q.delete();
        step();
        step();
        pc_addr        = pc0;
        imem_req_ready = rq_rdy;
        instr_ready    = i_rdy;
        mem_en         = men;
        rst_n          = 1'b1;
    endtask

    task automatic stop_at(input logic [31:0] stop_pc);
        for (int i = 0; i < 30; i++) begin
            if (pc_addr == stop_pc) break;
            step();
        end
        imem_req_ready = 1'b0;
        chk("stop_pc_reached", pc_addr, stop_pc);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        step();
        step();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_idle", instr_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        flush          = 1'b0;
        pc_addr        = '0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_valid", imem_req_valid, 0);
        chk("reset_pc_advance", pc_advance, 0);
        chk("reset_instr_valid", instr_valid, 0);
        chk("reset_fetch_fault", fetch_fault, 0);

        // Streaming, 1-cycle memory, decode always ready.
        do_reset(32'h0, 1'b1, 1'b1, 1'b1);
        expect_instr(32'h0, 32'hC0DE0000);
        expect_instr(32'h4, 32'hC0DE0004);
        expect_instr(32'h8, 32'hC0DE0008);
        expect_instr(32'hC, 32'hC0DE000C);
        @(negedge clk);
        chk("stream_c0_advance", pc_advance, 1);
        chk("stream_c0_invalid", instr_valid, 0);
        step();
        @(negedge clk);
        chk("stream_c1_invalid", instr_valid, 0);
        step();
        @(negedge clk);
        chk("stream_c2_valid", instr_valid, 1);
        stop_at(32'h10);
        drain();
        chk("stream_idle_req", imem_req_valid, 1);
        chk("stream_idle_no_adv", pc_advance, 0);

        // Backpressure: ring fills, no same-cycle bypass on the first pop.
        do_reset(32'h0, 1'b1, 1'b0, 1'b1);
        expect_instr(32'h0, 32'hC0DE0000);
        expect_instr(32'h4, 32'hC0DE0004);
        expect_instr(32'h8, 32'hC0DE0008);
        @(negedge clk);
        chk("bp_c0_advance", pc_advance, 1);
        step();
        @(negedge clk);
        chk("bp_c1_advance", pc_advance, 1);
        step();
        @(negedge clk);
        chk("bp_full_no_req", imem_req_valid, 0);
        chk("bp_head_valid", instr_valid, 1);
        step();
        instr_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_bypass", imem_req_valid, 0);
        step();
        @(negedge clk);
        chk("bp_resume_req", imem_req_valid, 1);
        chk("bp_resume_addr", imem_req_addr, 32'h8);
        step();
        imem_req_ready = 1'b0;
        drain();

        // Flush with two requests in flight and no responses yet.
        do_reset(32'h10, 1'b1, 1'b1, 1'b0);
        expect_instr(32'h40, 32'hC0DE0040);
        expect_instr(32'h44, 32'hC0DE0044);
        step();
        step();
        flush   = 1'b1;
        pc_addr = 32'h40;
        @(negedge clk);
        chk("flush_no_req", imem_req_valid, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drops_block", imem_req_valid, 0);
        mem_en = 1'b1;
        step();
        @(negedge clk);
        chk("flush_drop2_block", imem_req_valid, 0);
        step();
        @(negedge clk);
        chk("flush_resume_req", imem_req_valid, 1);
        chk("flush_resume_addr", imem_req_addr, 32'h40);
        stop_at(32'h48);
        drain();

        // Flush in the same cycle as the response for 0x10.
        do_reset(32'h10, 1'b1, 1'b1, 1'b0);
        expect_instr(32'h40, 32'hC0DE0040);
        expect_instr(32'h44, 32'hC0DE0044);
        step();
        step();
        mem_en = 1'b1;
        step();
        flush   = 1'b1;
        pc_addr = 32'h40;
        @(negedge clk);
        chk("flush_rsp_no_req", imem_req_valid, 0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_rsp_one_drop", imem_req_valid, 1);
        chk("flush_rsp_addr", imem_req_addr, 32'h40);
        stop_at(32'h48);
        drain();

        // Asynchronous reset between clock edges with an instruction pending.
        do_reset(32'h200, 1'b1, 1'b0, 1'b1);
        step();
        imem_req_ready = 1'b0;
        step();
        @(negedge clk);
        chk("pre_rst_instr_valid", instr_valid, 1);
        chk("pre_rst_req_valid", imem_req_valid, 1);
        #1 imem_req_ready = 1'b1;
        #1 chk("pre_rst_advance", pc_advance, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_instr_valid", instr_valid, 0);
        chk("async_rst_req_valid", imem_req_valid, 0);
        chk("async_rst_advance", pc_advance, 0);

`ifdef MISALIGN_TRAP_EN
        // Misaligned PC traps; flush to an aligned target clears it.
        do_reset(32'h6, 1'b1, 1'b1, 1'b1);
        expect_instr(32'h8, 32'hC0DE0008);
        @(negedge clk);
        chk("mis_no_req", imem_req_valid, 0);
        chk("mis_no_advance", pc_advance, 0);
        chk("mis_fault_c0", fetch_fault, 0);
        step();
        @(negedge clk);
        chk("mis_fault_set", fetch_fault, 1);
        chk("mis_still_no_req", imem_req_valid, 0);
        step();
        @(negedge clk);
        chk("mis_fault_hold", fetch_fault, 1);
        step();
        flush   = 1'b1;
        pc_addr = 32'h8;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("mis_fault_clear", fetch_fault, 0);
        chk("mis_resume_req", imem_req_valid, 1);
        chk("mis_resume_addr", imem_req_addr, 32'h8);
        stop_at(32'hC);
        drain();
`else
        // Without the trap a misaligned PC is fetched like any other.
        do_reset(32'h6, 1'b1, 1'b1, 1'b1);
        expect_instr(32'h6, 32'hC0DE0006);
        @(negedge clk);
        chk("noalign_req", imem_req_valid, 1);
        chk("noalign_addr", imem_req_addr, 32'h6);
        chk("noalign_fault", fetch_fault, 0);
        stop_at(32'hA);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
